// File: rtl/key_filter_pkg.sv
// Shared definitions for the push-button debounce block: FSM state encoding and
// default timing for a 50 MHz clock with a 20 ms debounce window.
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_e;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_CYC_50M = 1_000_000;
  localparam int CNT_W_DEF        = 24;

endpackage

// File: rtl/key_filter_if.sv
// Pin-side and consumer-side signals of one debounced KEY input.
interface key_filter_if;
  logic key_in;
  logic key_flag;
  logic key_state;
  logic key_run;
  logic key_rel;

  modport master (output key_in, input key_flag, key_state, key_run, key_rel);
  modport slave  (input key_in, output key_flag, key_state, key_run, key_rel);
endinterface

// File: rtl/key_sync.sv
// N-stage synchronizer for active-low board inputs; resets to 1 (released) so a
// reset never looks like a press. Reused by every KEY input.
module key_sync #(
  parameter int STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  generate
    if (STAGES == 1) begin : g_one
      always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) sync_q <= 1'b1;
        else        sync_q <= d;
      end
    end else begin : g_multi
      always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[STAGES-2:0], d};
      end
    end
  endgenerate

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/key_filter.sv
// Debounces one active-low push-button: synchronizer, 4-state filter FSM and
// registered flag/level outputs. Define KEY_RELEASE_FLAG_EN to enable key_rel.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_50M,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  key_filter_if.slave kif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             key_s;
  key_fsm_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_flag_q, flag_d;
  logic             key_state_q, lvl_d;
  logic             key_run_q, run_d;

  key_sync #(.STAGES(2)) u_sync (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .d        (kif.key_in),
    .q        (key_s)
  );

`ifdef KEY_RELEASE_FLAG_EN
  logic key_rel_q, rel_d;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) key_rel_q <= 1'b0;
    else        key_rel_q <= rel_d;
  end

  assign kif.key_rel = key_rel_q;
`else
  assign kif.key_rel = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_flag_q  <= 1'b0;
      key_state_q <= 1'b0;
      key_run_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_flag_q  <= flag_d;
      key_state_q <= lvl_d;
      key_run_q   <= run_d;
    end
  end

  // The counter is cleared on every state change, so it never needs to wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = 1'b0;
    lvl_d   = key_state_q;
    run_d   = key_run_q;
`ifdef KEY_RELEASE_FLAG_EN
    rel_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_FILT;
          cnt_d   = '0;
        end
      end
      PRESS_FILT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
          flag_d  = 1'b1;
          lvl_d   = 1'b1;
          run_d   = ~key_run_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (key_s) begin
          state_d = REL_FILT;
          cnt_d   = '0;
        end
      end
      REL_FILT: begin
        if (!key_s) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          lvl_d   = 1'b0;
`ifdef KEY_RELEASE_FLAG_EN
          rel_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign kif.key_flag  = key_flag_q;
  assign kif.key_state = key_state_q;
  assign kif.key_run   = key_run_q;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter with DEBOUNCE_CYC=100, compared against a run-length
// reference model of the debounce rule.
module tb_key_filter;

  localparam int D = 100;
`ifdef KEY_RELEASE_FLAG_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  key_filter_if kif ();

  key_filter #(.DEBOUNCE_CYC(D), .CNT_W(8)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .kif      (kif)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference: the pin is seen two edges late; the debounced level flips once
  // the seen level has disagreed with it for D+1 consecutive edges.
  logic [1:0] m_d;
  logic       m_lvl, m_flag, m_run, m_rel;
  int         m_len;

  always @(posedge CLOCK_50 or negedge rst_n) begin : mdl
    logic pressed;
    int   len;
    if (!rst_n) begin
      m_d    <= 2'b11;
      m_lvl  <= 1'b0;
      m_len  <= 0;
      m_flag <= 1'b0;
      m_run  <= 1'b0;
      m_rel  <= 1'b0;
    end else begin
      pressed = ~m_d[1];
      len     = (pressed == m_lvl) ? 0 : m_len + 1;
      m_d    <= {m_d[0], kif.key_in};
      m_flag <= 1'b0;
      m_rel  <= 1'b0;
      if (len == D + 1) begin
        m_lvl <= pressed;
        m_len <= 0;
        if (pressed) begin
          m_flag <= 1'b1;
          m_run  <= ~m_run;
        end else begin
          m_rel  <= REL_EN;
        end
      end else begin
        m_len <= len;
      end
    end
  end

  logic [3:0] obs, exp_v;

  task automatic apply_reset();
    @(negedge CLOCK_50);
    rst_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    kif.key_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    obs = {kif.key_flag, kif.key_state, kif.key_run, kif.key_rel};
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold outputs got %b expected 0000", obs);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge CLOCK_50);
      obs = {kif.key_flag, kif.key_state, kif.key_run, kif.key_rel};
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got %b expected 0000", k, obs);
      end
    end
  endtask

  task automatic test_clean_press();
    int first, nflag;
    kif.key_in = 1'b1;
    apply_reset();
    first = -1;
    nflag = 0;
    @(negedge CLOCK_50);
    kif.key_in = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge CLOCK_50);
      obs   = {kif.key_flag, kif.key_state, kif.key_run, kif.key_rel};
      exp_v = {m_flag, m_lvl, m_run, m_rel};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL press_model cycle %0d got %b expected %b", k, obs, exp_v);
      end
      if (kif.key_flag) begin
        nflag++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first != D + 3) begin
      errors++;
      $display("FAIL press_latency got %0d expected %0d", first, D + 3);
    end
    checks++;
    if (nflag != 1) begin
      errors++;
      $display("FAIL press_flag_count got %0d expected 1", nflag);
    end
    checks++;
    if ({kif.key_state, kif.key_run} !== 2'b11) begin
      errors++;
      $display("FAIL press_levels got %b expected 11", {kif.key_state, kif.key_run});
    end
  endtask

  task automatic test_bounce();
    int first, nflag;
    kif.key_in = 1'b1;
    apply_reset();
    nflag = 0;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 60; k++) begin
        @(negedge CLOCK_50);
        obs   = {kif.key_flag, kif.key_state, kif.key_run, kif.key_rel};
        exp_v = {m_flag, m_lvl, m_run, m_rel};
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL bounce_model burst %0d cycle %0d got %b expected %b", b, k, obs, exp_v);
        end
        if (kif.key_flag) nflag++;
        kif.key_in = (k < 50) ? 1'b0 : 1'b1;
      end
    end
    checks++;
    if (nflag != 0) begin
      errors++;
      $display("FAIL bounce_no_flag got %0d expected 0", nflag);
    end
    @(negedge CLOCK_50);
    kif.key_in = 1'b0;
    first = -1;
    for (int k = 1; k <= 150; k++) begin
      @(negedge CLOCK_50);
      obs   = {kif.key_flag, kif.key_state, kif.key_run, kif.key_rel};
      exp_v = {m_flag, m_lvl, m_run, m_rel};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounce_hold_model cycle %0d got %b expected %b", k, obs, exp_v);
      end
      if (kif.key_flag) begin
        nflag++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (first != D + 3 || nflag != 1) begin
      errors++;
      $display("FAIL bounce_final_flag at %0d count %0d expected at %0d count 1", first, nflag, D + 3);
    end
  endtask

  task automatic test_release();
    int fall, nrel;
    bit rel_at_fall;
    kif.key_in = 1'b1;
    apply_reset();
    @(negedge CLOCK_50);
    kif.key_in = 1'b0;
    repeat (150) @(negedge CLOCK_50);
    kif.key_in = 1'b1;
    fall = -1;
    nrel = 0;
    rel_at_fall = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge CLOCK_50);
      obs   = {kif.key_flag, kif.key_state, kif.key_run, kif.key_rel};
      exp_v = {m_flag, m_lvl, m_run, m_rel};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL release_model cycle %0d got %b expected %b", k, obs, exp_v);
      end
      if (kif.key_rel) nrel++;
      if (fall < 0 && !kif.key_state) begin
        fall = k;
        rel_at_fall = kif.key_rel;
      end
    end
    checks++;
    if (fall != D + 3) begin
      errors++;
      $display("FAIL release_latency got %0d expected %0d", fall, D + 3);
    end
    checks++;
    if (nrel != int'(REL_EN) || rel_at_fall != REL_EN) begin
      errors++;
      $display("FAIL release_rel_pulse count %0d at_fall %0d expected count %0d", nrel, rel_at_fall, REL_EN);
    end
  endtask

  task automatic test_toggle();
    logic run_seen [3];
    logic exp_run  [3];
    int nflag;
    exp_run[0] = 1'b1;
    exp_run[1] = 1'b0;
    exp_run[2] = 1'b1;
    kif.key_in = 1'b1;
    apply_reset();
    nflag = 0;
    for (int p = 0; p < 6; p++) begin
      @(negedge CLOCK_50);
      kif.key_in = p[0];
      for (int k = 0; k < 120; k++) begin
        @(negedge CLOCK_50);
        obs   = {kif.key_flag, kif.key_state, kif.key_run, kif.key_rel};
        exp_v = {m_flag, m_lvl, m_run, m_rel};
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL toggle_model phase %0d cycle %0d got %b expected %b", p, k, obs, exp_v);
        end
        if (kif.key_flag) begin
          if (nflag < 3) run_seen[nflag] = kif.key_run;
          nflag++;
        end
      end
    end
    checks++;
    if (nflag != 3) begin
      errors++;
      $display("FAIL toggle_flag_count got %0d expected 3", nflag);
    end
    for (int i = 0; i < 3 && i < nflag; i++) begin
      checks++;
      if (run_seen[i] !== exp_run[i]) begin
        errors++;
        $display("FAIL toggle_run_%0d got %b expected %b", i, run_seen[i], exp_run[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int first;
    kif.key_in = 1'b1;
    apply_reset();
    first = -1;
    @(negedge CLOCK_50);
    kif.key_in = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge CLOCK_50);
      obs   = {kif.key_flag, kif.key_state, kif.key_run, kif.key_rel};
      exp_v = {m_flag, m_lvl, m_run, m_rel};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL midreset_model cycle %0d got %b expected %b", k, obs, exp_v);
      end
      if (k > 60 && k <= 70) begin
        checks++;
        if (obs !== 4'b0000) begin
          errors++;
          $display("FAIL midreset_hold cycle %0d got %b expected 0000", k, obs);
        end
      end
      if (kif.key_flag && first < 0) first = k;
      if (k == 60) rst_n = 1'b0;
      if (k == 70) rst_n = 1'b1;
    end
    checks++;
    if (first != 70 + D + 3 || kif.key_run !== 1'b1) begin
      errors++;
      $display("FAIL midreset_confirm flag at %0d run %b expected at %0d run 1", first, kif.key_run, 70 + D + 3);
    end
  endtask

  task automatic test_random();
    int remain;
    remain = 0;
    kif.key_in = 1'b1;
    apply_reset();
    for (int k = 0; k < 4000; k++) begin
      @(negedge CLOCK_50);
      obs   = {kif.key_flag, kif.key_state, kif.key_run, kif.key_rel};
      exp_v = {m_flag, m_lvl, m_run, m_rel};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random_model cycle %0d got %b expected %b", k, obs, exp_v);
      end
      checks++;
      if (kif.key_flag && kif.key_rel) begin
        errors++;
        $display("FAIL random_flag_rel_overlap cycle %0d got 11 expected not both", k);
      end
      if (remain == 0) begin
        kif.key_in = ~kif.key_in;
        remain = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 250))
                                             : int'($urandom_range(1, 110));
      end else begin
        remain--;
      end
    end
  endtask

  initial begin
    kif.key_in = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_toggle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
